// File: rtl/clk_div_bank_if.sv
// Bus bundle for clk_div_bank: the half-period register write/readback port,
// per-channel run enables, global sync, and the divided clock/tick outputs.
interface clk_div_bank_if #(
  parameter int NumChannels = 4,
  parameter int CountWidth  = 16,
  parameter int AddrWidth   = 2
);
  logic                   _iWe;
  logic [AddrWidth-1:0]   _iAddr;
  logic [CountWidth-1:0]  _iWrData;
  logic [NumChannels-1:0] _iEn;
  logic                   _iSync;
  logic [CountWidth-1:0]  _oRdData;
  logic [NumChannels-1:0] _oClkDiv;
  logic [NumChannels-1:0] _oTick;

  // Controller side: drives writes, enables and sync; observes the outputs.
  modport master (
    output _iWe, _iAddr, _iWrData, _iEn, _iSync,
    input  _oRdData, _oClkDiv, _oTick
  );

  // Divider bank side.
  modport slave (
    input  _iWe, _iAddr, _iWrData, _iEn, _iSync,
    output _oRdData, _oClkDiv, _oTick
  );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable / divided-clock generator.
// Each channel counts up to its active half-period H and toggles its output,
// giving a 50% duty square wave of period 2*(H+1) system clocks plus a
// one-cycle tick on every rising edge. New H values are staged in a shadow
// register and only take effect at a half-period boundary (or immediately
// while the channel is idle), so a running output never sees a runt phase.
module clk_div_bank #(
  parameter int NumChannels     = 4,
  parameter int CountWidth      = 16,
  parameter int AddrWidth       = 2,
  parameter int ResetHalfPeriod = 0
) (
  input  logic           _iClk,
  input  logic           _iRst_n,
  clk_div_bank_if.slave  bus
);

  localparam logic [CountWidth-1:0] ResetH = CountWidth'(ResetHalfPeriod);

  logic [CountWidth-1:0]  cnt_r       [NumChannels];
  logic [CountWidth-1:0]  activeH_r   [NumChannels];
  logic [CountWidth-1:0]  shadowH_r   [NumChannels];
  logic [NumChannels-1:0] clkDiv_r;
  logic [NumChannels-1:0] tick_r;
  logic [CountWidth-1:0]  rdData_r;

  logic [CountWidth-1:0]  nextShadow_s [NumChannels];
  logic [NumChannels-1:0] wrap_s;
  logic [CountWidth-1:0]  rdSel_s;

  // Shadow value each channel holds after this edge (a same-cycle write wins) and wrap detect.
  always_comb begin
    wrap_s = '0;
    for (int i = 0; i < NumChannels; i++) begin
      nextShadow_s[i] = (bus._iWe && (bus._iAddr == AddrWidth'(i))) ? bus._iWrData : shadowH_r[i];
      wrap_s[i]       = (cnt_r[i] == activeH_r[i]);
    end
  end

  // Readback mux: out-of-range addresses match no channel and read as zero.
  always_comb begin
    rdSel_s = '0;
    for (int i = 0; i < NumChannels; i++) begin
      rdSel_s = (bus._iAddr == AddrWidth'(i)) ? activeH_r[i] : rdSel_s;
    end
  end

  // Per-channel divider state machine plus the registered readback.
  always_ff @(posedge _iClk) begin
    if (!_iRst_n) begin
      for (int i = 0; i < NumChannels; i++) begin
        cnt_r[i]     <= '0;
        activeH_r[i] <= ResetH;
        shadowH_r[i] <= ResetH;
      end
      clkDiv_r <= '0;
      tick_r   <= '0;
      rdData_r <= '0;
    end else begin
      rdData_r <= rdSel_s;
      for (int i = 0; i < NumChannels; i++) begin
        shadowH_r[i] <= nextShadow_s[i];
        if (bus._iSync || !bus._iEn[i]) begin
          // Idle or restarting: park low and adopt the latest programmed H.
          cnt_r[i]     <= '0;
          clkDiv_r[i]  <= 1'b0;
          tick_r[i]    <= 1'b0;
          activeH_r[i] <= nextShadow_s[i];
        end else if (wrap_s[i]) begin
          // Half-period boundary: toggle, tick only on the rising transition.
          cnt_r[i]     <= '0;
          clkDiv_r[i]  <= ~clkDiv_r[i];
          tick_r[i]    <= ~clkDiv_r[i];
          activeH_r[i] <= nextShadow_s[i];
        end else begin
          cnt_r[i]     <= cnt_r[i] + CountWidth'(1);
          clkDiv_r[i]  <= clkDiv_r[i];
          tick_r[i]    <= 1'b0;
          activeH_r[i] <= activeH_r[i];
        end
      end
    end
  end

  assign bus._oRdData = rdData_r;
  assign bus._oClkDiv = clkDiv_r;
  assign bus._oTick   = tick_r;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios with hand-computed
// expectations, then randomized traffic compared every cycle against a
// timestamp-based behavioural model of the divider bank.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int AW  = 2;
  localparam int RHP = 0;

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFail   = 0;

  clk_div_bank_if #(.NumChannels(NCH), .CountWidth(CW), .AddrWidth(AW)) bus ();

  clk_div_bank #(
    .NumChannels(NCH), .CountWidth(CW), .AddrWidth(AW), .ResetHalfPeriod(RHP)
  ) dut (
    ._iClk  (clk),
    ._iRst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel remembers the cycle at which its current half-period began
  // and the H governing it; it toggles when exactly H+1 running cycles elapsed.
  longint cyc = 0;
  longint mStart [NCH];
  int     mH     [NCH];
  int     mShadow[NCH];
  bit     mLvl   [NCH];
  bit     mTick  [NCH];
  int     mRd    = 0;
  bit     mValid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        mLvl[i] = 1'b0; mTick[i] = 1'b0;
        mH[i] = RHP; mShadow[i] = RHP; mStart[i] = cyc;
      end
      mRd = 0;
    end else begin
      mRd = (int'(bus._iAddr) < NCH) ? mH[int'(bus._iAddr)] : 0;
      for (int i = 0; i < NCH; i++) begin
        if (bus._iWe && int'(bus._iAddr) == i) mShadow[i] = int'(bus._iWrData);
        if (bus._iSync || !bus._iEn[i]) begin
          mLvl[i] = 1'b0; mTick[i] = 1'b0; mH[i] = mShadow[i]; mStart[i] = cyc;
        end else if (cyc - mStart[i] == longint'(mH[i]) + 1) begin
          mTick[i] = !mLvl[i]; mLvl[i] = !mLvl[i]; mH[i] = mShadow[i]; mStart[i] = cyc;
        end else begin
          mTick[i] = 1'b0;
        end
      end
    end
    mValid = 1'b1;
  end

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    logic [NCH-1:0] eClk, eTick;
    if (mValid) begin
      for (int i = 0; i < NCH; i++) begin
        eClk[i]  = mLvl[i];
        eTick[i] = mTick[i];
      end
      check("model_clkdiv", 32'(bus._oClkDiv), 32'(eClk));
      check("model_tick",   32'(bus._oTick),   32'(eTick));
      check("model_rddata", 32'(bus._oRdData), 32'(mRd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int a, input int d);
    bus._iWe = 1'b1; bus._iAddr = AW'(a); bus._iWrData = CW'(d);
    @(negedge clk);
    bus._iWe = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus._iWe = 1'b0; bus._iAddr = '0; bus._iWrData = '0; bus._iEn = '0; bus._iSync = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_clkdiv", 32'(bus._oClkDiv), 32'd0);
    check("reset_tick",   32'(bus._oTick),   32'd0);
    check("reset_rddata", 32'(bus._oRdData), 32'd0);

    // ch0 with reset H=0 toggles every cycle
    rst_n = 1'b1; bus._iEn = 3'b001;
    @(negedge clk); check("h0_rise_clk", 32'(bus._oClkDiv), 32'd1); check("h0_rise_tick", 32'(bus._oTick), 32'd1);
    @(negedge clk); check("h0_fall_clk", 32'(bus._oClkDiv), 32'd0); check("h0_fall_tick", 32'(bus._oTick), 32'd0);
    @(negedge clk); check("h0_rise2_clk", 32'(bus._oClkDiv), 32'd1);

    // ch1 H=3 written while idle, then enabled: first rise after 4 edges, period 8
    wr(1, 3);
    bus._iEn = 3'b011;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus._oClkDiv[1] && k < 20);
    check("h3_first_rise_delay", 32'(k), 32'd4);
    check("h3_first_tick", 32'(bus._oTick[1]), 32'd1);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      check("h3_wave", 32'(bus._oClkDiv[1]), (j < 4) ? 32'd1 : 32'd0);
      check("h3_tick_quiet", 32'(bus._oTick[1]), 32'd0);
    end
    @(negedge clk);
    check("h3_second_rise", 32'(bus._oClkDiv[1]), 32'd1);
    check("h3_second_tick", 32'(bus._oTick[1]), 32'd1);
    check("h3_readback", 32'(bus._oRdData), 32'd3);

    // Mid-high-phase write H=1: high phase still lasts 4, then low 2
    wr(1, 1);
    check("midwr_clk_j9", 32'(bus._oClkDiv[1]), 32'd1); check("midwr_rd_j9", 32'(bus._oRdData), 32'd3);
    @(negedge clk); check("midwr_clk_j10", 32'(bus._oClkDiv[1]), 32'd1); check("midwr_rd_j10", 32'(bus._oRdData), 32'd3);
    @(negedge clk); check("midwr_clk_j11", 32'(bus._oClkDiv[1]), 32'd1); check("midwr_rd_j11", 32'(bus._oRdData), 32'd3);
    @(negedge clk); check("midwr_clk_j12", 32'(bus._oClkDiv[1]), 32'd0); check("midwr_rd_j12", 32'(bus._oRdData), 32'd3);
    @(negedge clk); check("midwr_clk_j13", 32'(bus._oClkDiv[1]), 32'd0); check("midwr_rd_j13", 32'(bus._oRdData), 32'd1);
    @(negedge clk); check("midwr_clk_j14", 32'(bus._oClkDiv[1]), 32'd1);

    // Out-of-range address: write ignored, readback zero
    wr(3, 7);
    @(negedge clk); check("addr3_readback", 32'(bus._oRdData), 32'd0);

    // All-ones H on ch2: first rise after 256 edges
    wr(2, 255);
    bus._iEn = 3'b111;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus._oClkDiv[2] && k < 600);
    check("hmax_first_rise_delay", 32'(k), 32'd256);

    // Sync alignment: ch0, ch2 at H=2 enabled one cycle apart
    bus._iEn = 3'b000;
    @(negedge clk);
    wr(0, 2);
    wr(2, 2);
    bus._iEn = 3'b001; @(negedge clk);
    bus._iEn = 3'b101; @(negedge clk); @(negedge clk);
    bus._iSync = 1'b1; @(negedge clk);
    bus._iSync = 1'b0;
    check("sync_parks_low", 32'(bus._oClkDiv), 32'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(bus._oClkDiv[0] || bus._oClkDiv[2]) && k < 20);
    check("sync_rise_delay", 32'(k), 32'd3);
    check("sync_aligned", 32'(bus._oClkDiv), 32'b101);

    // Drop ch2 during its high phase; re-enable gives a full low phase
    bus._iEn = 3'b001; @(negedge clk);
    check("drop_ch2_low", 32'(bus._oClkDiv[2]), 32'd0);
    check("drop_ch2_notick", 32'(bus._oTick[2]), 32'd0);
    check("drop_ch0_still_high", 32'(bus._oClkDiv[0]), 32'd1);
    bus._iEn = 3'b101;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus._oClkDiv[2] && k < 20);
    check("reenable_rise_delay", 32'(k), 32'd3);

    // Reset mid-run
    bus._iAddr = 2'd1;
    rst_n = 1'b0; @(negedge clk);
    check("midreset_clkdiv", 32'(bus._oClkDiv), 32'd0);
    check("midreset_tick",   32'(bus._oTick),   32'd0);
    check("midreset_rddata", 32'(bus._oRdData), 32'd0);
    rst_n = 1'b1; bus._iEn = '0;
    @(negedge clk); check("midreset_h_restored", 32'(bus._oRdData), 32'(RHP));

    // Randomized traffic checked by the model
    for (int n = 0; n < 5000; n++) begin
      rst_n        = ($urandom_range(0, 799) != 0);
      bus._iWe     = ($urandom_range(0, 3) == 0);
      bus._iAddr   = AW'($urandom_range(0, 3));
      bus._iWrData = ($urandom_range(0, 19) == 0) ? CW'(255) : CW'($urandom_range(0, 5));
      bus._iSync   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 24) == 0) bus._iEn[$urandom_range(0, NCH-1)] ^= 1'b1;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
